// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated-window frequency meter.
`timescale 1ns/1ps
package freq_meter_pkg;

    typedef enum logic [1:0] {
        GATE  = 2'd0,
        LATCH = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam int         DEFAULT_CLK_HZ = 50_000_000;

endpackage

// File: rtl/freq_meter_bcd_digit.sv
// One decade of the BCD event counter; carry fires when this digit wraps 9 -> 0.
`timescale 1ns/1ps
module bcd_digit
    import freq_meter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    assign carry = (q == BCD_MAX) && inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (inc) begin
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts sig_in rising edges over GATE_CYCLES clocks
// and latches the result as packed BCD.
`timescale 1ns/1ps
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ      = DEFAULT_CLK_HZ,
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sig_in,
    input  logic                    hold,
    output logic [4*NUM_DIGITS-1:0] freq_bcd,
    output logic                    valid,
    output logic                    ovf
);

    localparam int             GCW       = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GCW-1:0] GATE_LAST = GCW'(GATE_CYCLES - 1);

    logic                    sync1, sync2, sync3;
    logic                    edge_pulse;
    state_t                  state, state_nxt;
    logic [GCW-1:0]          gate_cnt;
    logic                    count_en;
    logic                    digit_clr;
    logic                    all9;
    logic                    sat;
    logic [NUM_DIGITS-1:0]   is9;
    logic [NUM_DIGITS:0]     inc_chain;
    logic [4*NUM_DIGITS-1:0] bcd_cnt;

    // Input synchronizer plus one extra stage for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_pulse = sync2 & ~sync3;

    // Window sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            GATE:    if (gate_cnt == GATE_LAST) state_nxt = LATCH;
            LATCH:   state_nxt = CLEAR;
            CLEAR:   state_nxt = GATE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
        end else if (state == CLEAR) begin
            gate_cnt <= '0;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    // BCD counter: edges only count during GATE, and stop advancing at all-9s
    assign count_en     = (state == GATE) && edge_pulse;
    assign digit_clr    = (state == CLEAR);
    assign all9         = &is9;
    assign inc_chain[0] = count_en & ~all9;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        assign is9[k] = (bcd_cnt[4*k +: 4] == BCD_MAX);

        bcd_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc_chain[k]),
            .clr   (digit_clr),
            .q     (bcd_cnt[4*k +: 4]),
            .carry (inc_chain[k+1])
        );
    end

    // A carry out of the top digit would be a wrap, so it also marks saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (state == CLEAR) begin
            sat <= 1'b0;
        end else if ((count_en && all9) || inc_chain[NUM_DIGITS]) begin
            sat <= 1'b1;
        end
    end

    // Result registers: updated only in LATCH, and only when not held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_bcd <= '0;
            ovf      <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= (state == LATCH) && !hold;
            if ((state == LATCH) && !hold) begin
                freq_bcd <= bcd_cnt;
                ovf      <= sat;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: an 8-digit and a 2-digit instance run window-aligned schedules.
`timescale 1ns/1ps
module tb_freq_meter;

    localparam int GC  = 1000;
    localparam int WIN = GC + 2;

    localparam logic [1:0] M_SQ = 2'd0;
    localparam logic [1:0] M_C0 = 2'd1;
    localparam logic [1:0] M_C1 = 2'd2;
    localparam logic [1:0] M_SE = 2'd3;

    typedef struct packed {
        logic [1:0]  mode;
        logic [11:0] per;
        logic        hold;
        logic [31:0] bcd;
        logic        ovf;
    } win_t;

    typedef struct packed {
        logic [31:0] bcd;
        logic        ovf;
        logic [15:0] gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  sig_v;
    logic [1:0]  hold_v;
    logic [31:0] bcd0;
    logic [7:0]  bcd1;
    logic [1:0]  valid_v;
    logic [1:0]  ovf_v;
    logic [31:0] bcd_a [2];
    int          cyc;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        q0 [$];
    exp_t        q1 [$];
    win_t        sched [2][13];
    win_t        post_w [2];
    win_t        idle;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    assign bcd_a[0] = bcd0;
    assign bcd_a[1] = {24'd0, bcd1};

    freq_meter #(.CLK_HZ(GC), .GATE_CYCLES(GC), .NUM_DIGITS(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_v[0]), .hold(hold_v[0]),
        .freq_bcd(bcd0), .valid(valid_v[0]), .ovf(ovf_v[0])
    );

    freq_meter #(.CLK_HZ(GC), .GATE_CYCLES(GC), .NUM_DIGITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_v[1]), .hold(hold_v[1]),
        .freq_bcd(bcd1), .valid(valid_v[1]), .ovf(ovf_v[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic win_t mk(input logic [1:0] mode, input int per, input logic hold,
                                input logic [31:0] bcd, input logic ovf);
        win_t w;
        w.mode = mode;
        w.per  = 12'(per);
        w.hold = hold;
        w.bcd  = bcd;
        w.ovf  = ovf;
        return w;
    endfunction

    // Level of sig_in at phase p of a window; p 0..999 are counted, 1000..1001 are dead time
    function automatic logic wave(input win_t cur, input win_t nxt, input int p);
        int   per;
        logic v;
        per = int'(cur.per);
        case (cur.mode)
            M_SQ:    v = (p % per) >= (per / 2);
            M_C1:    v = 1'b1;
            M_SE:    v = (p >= per) && (p < per + 3);
            default: v = 1'b0;
        endcase
        if (p >= 1000 && nxt.mode == M_C1) v = 1'b1;
        return v;
    endfunction

    task automatic push(input int idx, input logic [31:0] bcd, input logic ovf, input int gap);
        exp_t e;
        e.bcd = bcd;
        e.ovf = ovf;
        e.gap = 16'(gap);
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic drive_win(input int idx, input win_t cur, input win_t nxt,
                             input logic prev_hold, input int p_first, input int p_last);
        for (int p = p_first; p <= p_last; p++) begin
            @(posedge clk);
            #1;
            sig_v[idx]  = wave(cur, nxt, p);
            hold_v[idx] = (p == 0) ? prev_hold : (cur.hold | (p >= 300 && p < 310));
        end
    endtask

    task automatic run_dut(input int idx);
        int   skip = 0;
        logic ph = 1'b0;
        for (int w = 0; w < 12; w++) begin
            if (!sched[idx][w].hold) begin
                push(idx, sched[idx][w].bcd, sched[idx][w].ovf, WIN * (skip + 1));
                skip = 0;
            end else begin
                skip++;
            end
            drive_win(idx, sched[idx][w], sched[idx][w+1], ph, (w == 0) ? 2 : 0, WIN - 1);
            ph = sched[idx][w].hold;
        end
        drive_win(idx, sched[idx][12], sched[idx][12], ph, 0, 499);
    endtask

    task automatic run_post(input int idx);
        push(idx, post_w[idx].bcd, post_w[idx].ovf, WIN);
        drive_win(idx, post_w[idx], idle, 1'b0, 2, WIN - 1);
        drive_win(idx, idle, idle, 1'b0, 0, 19);
    endtask

    task automatic monitor(input int idx);
        int          last_v = 0;
        logic [31:0] last_b = '0;
        logic        last_o = 1'b0;
        exp_t        e;
        int          qn;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_v = 0;
                last_b = '0;
                last_o = 1'b0;
            end else if (valid_v[idx]) begin
                qn = (idx == 0) ? q0.size() : q1.size();
                if (qn == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dut%0d_unexpected_valid: got valid with bcd %h, expected no valid (t=%0t)",
                             idx, bcd_a[idx], $time);
                end else begin
                    if (idx == 0) e = q0.pop_front();
                    else          e = q1.pop_front();
                    check($sformatf("dut%0d_bcd", idx), bcd_a[idx], e.bcd);
                    check($sformatf("dut%0d_ovf", idx), 32'(ovf_v[idx]), 32'(e.ovf));
                    check($sformatf("dut%0d_gap", idx), 32'(cyc - last_v), 32'(e.gap));
                end
                last_v = cyc;
                last_b = bcd_a[idx];
                last_o = ovf_v[idx];
            end else begin
                check($sformatf("dut%0d_bcd_stable", idx), bcd_a[idx], last_b);
                check($sformatf("dut%0d_ovf_stable", idx), 32'(ovf_v[idx]), 32'(last_o));
            end
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
    end

    initial begin
        #400_000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        idle = mk(M_C0, 1, 1'b0, 32'h0, 1'b0);

        sched[0][0]  = mk(M_SQ,   10, 1'b0, 32'h100, 1'b0);
        sched[0][1]  = mk(M_SQ,   10, 1'b0, 32'h100, 1'b0);
        sched[0][2]  = mk(M_SQ,   10, 1'b0, 32'h100, 1'b0);
        sched[0][3]  = mk(M_C0,    1, 1'b0, 32'h0,   1'b0);
        sched[0][4]  = mk(M_C1,    1, 1'b0, 32'h0,   1'b0);
        sched[0][5]  = mk(M_C1,    1, 1'b0, 32'h0,   1'b0);
        sched[0][6]  = mk(M_SE,  999, 1'b0, 32'h1,   1'b0);
        sched[0][7]  = mk(M_SE, 1000, 1'b0, 32'h0,   1'b0);
        sched[0][8]  = mk(M_C0,    1, 1'b0, 32'h0,   1'b0);
        sched[0][9]  = mk(M_SQ,   20, 1'b0, 32'h50,  1'b0);
        sched[0][10] = mk(M_SQ,   10, 1'b1, 32'h100, 1'b0);
        sched[0][11] = mk(M_SQ,    4, 1'b0, 32'h250, 1'b0);
        sched[0][12] = mk(M_SQ,   10, 1'b0, 32'h0,   1'b0);
        post_w[0]    = mk(M_SQ,    8, 1'b0, 32'h125, 1'b0);

        sched[1][0]  = mk(M_SQ,    4, 1'b0, 32'h99,  1'b1);
        sched[1][1]  = mk(M_SQ,   20, 1'b0, 32'h50,  1'b0);
        sched[1][2]  = mk(M_SQ,   10, 1'b0, 32'h99,  1'b1);
        sched[1][3]  = mk(M_SE,  999, 1'b0, 32'h1,   1'b0);
        sched[1][4]  = mk(M_C1,    1, 1'b0, 32'h0,   1'b0);
        sched[1][5]  = mk(M_SQ,  500, 1'b0, 32'h2,   1'b0);
        sched[1][6]  = mk(M_SQ,    4, 1'b1, 32'h99,  1'b1);
        for (int w = 7; w < 13; w++) sched[1][w] = idle;
        post_w[1]    = mk(M_SQ,   20, 1'b0, 32'h50,  1'b0);

        sig_v  = 2'b00;
        hold_v = 2'b00;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d_reset_bcd", i),   bcd_a[i],          32'h0);
            check($sformatf("dut%0d_reset_valid", i), 32'(valid_v[i]),   32'h0);
            check($sformatf("dut%0d_reset_ovf", i),   32'(ovf_v[i]),     32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        fork
            run_dut(0);
            run_dut(1);
        join

        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d_midreset_bcd", i),   bcd_a[i],        32'h0);
            check($sformatf("dut%0d_midreset_valid", i), 32'(valid_v[i]), 32'h0);
            check($sformatf("dut%0d_midreset_ovf", i),   32'(ovf_v[i]),   32'h0);
        end
        check("dut0_pending_before_reset", 32'(q0.size()), 32'h0);
        check("dut1_pending_before_reset", 32'(q1.size()), 32'h0);
        q0.delete();
        q1.delete();
        sig_v  = 2'b00;
        hold_v = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        fork
            run_post(0);
            run_post(1);
        join

        check("dut0_pending_at_end", 32'(q0.size()), 32'h0);
        check("dut1_pending_at_end", 32'(q1.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
